// File: rtl/axi_sram_responder_if.sv
// axi_sram_responder_if
// Purpose : AXI-lite style channel bundle (AR/R/AW/W/B) between the bus initiator and the SRAM responder.
// Ports   : 18-bit word addresses, 16-bit data, valid/ready on every channel; no write strobes or response codes.
// Modports: master = bus initiator side, slave = responder side.
interface axi_sram_responder_if;
  logic [17:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_ready;
  logic [17:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        b_valid;
  logic        b_ready;

  modport master (
    output ar_addr, ar_valid, input ar_ready,
    input  r_data, r_valid, output r_ready,
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_valid, input w_ready,
    input  b_valid, output b_ready
  );

  modport slave (
    input  ar_addr, ar_valid, output ar_ready,
    output r_data, r_valid, input r_ready,
    input  aw_addr, aw_valid, output aw_ready,
    input  w_data, w_valid, output w_ready,
    output b_valid, input b_ready
  );
endinterface

// File: rtl/axi_sram_responder.sv
// axi_sram_responder
// Purpose     : executes each AXI-lite read/write as one access to an asynchronous SRAM, WAIT_CYCLES extra strobe cycles.
// Latency     : read r_valid WAIT_CYCLES+2 cycles after the AR handshake cycle; write b_valid WAIT_CYCLES+4 cycles after AW and W are both held.
// Backpressure: one transaction in flight; all readies drop outside IDLE, R/B held stable until r_ready/b_ready.
// Ports       : clk, rst_n; axi (slave modport, AR/R/AW/W/B channels); sram_* pad-side pins (dq split into o/i/oe); busy.
module axi_sram_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_sram_responder_if.slave       axi,
  output logic [17:0]               sram_addr,
  output logic [15:0]               sram_dq_o,
  input  logic [15:0]               sram_dq_i,
  output logic                      sram_dq_oe,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic                      busy
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RD_STRB,
    RD_RESP,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        aw_held, aw_held_nxt;
  logic        w_held, w_held_nxt;
  logic [17:0] aw_addr_q, aw_addr_nxt;
  logic [15:0] w_data_q, w_data_nxt;
  logic        r_valid, r_valid_nxt;
  logic [15:0] r_data, r_data_nxt;
  logic        b_valid, b_valid_nxt;
  logic [17:0] addr_nxt;
  logic [15:0] dq_o_nxt;
  logic        dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;

  logic idle;
  logic ar_ready, aw_ready, w_ready;

  assign idle     = (state == IDLE);
  assign aw_ready = idle & ~aw_held;
  assign w_ready  = idle & ~w_held;
  // Any write activity, pending or just offered, blocks reads so writes win ties.
  assign ar_ready = idle & ~aw_held & ~w_held & ~axi.aw_valid & ~axi.w_valid;

  assign axi.ar_ready = ar_ready;
  assign axi.aw_ready = aw_ready;
  assign axi.w_ready  = w_ready;
  assign axi.r_valid  = r_valid;
  assign axi.r_data   = r_data;
  assign axi.b_valid  = b_valid;
  assign busy         = ~idle;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    aw_addr_nxt = aw_addr_q;
    w_data_nxt  = w_data_q;
    r_valid_nxt = r_valid;
    r_data_nxt  = r_data;
    b_valid_nxt = b_valid;
    addr_nxt    = sram_addr;
    dq_o_nxt    = sram_dq_o;
    dq_oe_nxt   = sram_dq_oe;
    ce_n_nxt    = sram_ce_n;
    oe_n_nxt    = sram_oe_n;
    we_n_nxt    = sram_we_n;

    // AW and W are captured independently; readies are already 0 outside IDLE.
    if (axi.aw_valid && aw_ready) begin
      aw_held_nxt = 1'b1;
      aw_addr_nxt = axi.aw_addr;
    end
    if (axi.w_valid && w_ready) begin
      w_held_nxt = 1'b1;
      w_data_nxt = axi.w_data;
    end

    case (state)
      IDLE: begin
        if (aw_held && w_held) begin
          // Address, data and chip enable go out together; WE stays high for setup.
          state_nxt   = WR_SETUP;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          addr_nxt    = aw_addr_q;
          dq_o_nxt    = w_data_q;
          dq_oe_nxt   = 1'b1;
          ce_n_nxt    = 1'b0;
          we_n_nxt    = 1'b1;
        end else if (axi.ar_valid && ar_ready) begin
          state_nxt = RD_STRB;
          addr_nxt  = axi.ar_addr;
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = 1'b0;
          cnt_nxt   = WAIT_CNT;
        end
      end
      RD_STRB: begin
        if (cnt == 4'd0) begin
          // Capture while OE is still low; the SRAM output is valid this cycle.
          r_data_nxt  = sram_dq_i;
          ce_n_nxt    = 1'b1;
          oe_n_nxt    = 1'b1;
          r_valid_nxt = 1'b1;
          state_nxt   = RD_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RD_RESP: begin
        if (axi.r_ready) begin
          r_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      WR_SETUP: begin
        cnt_nxt   = WAIT_CNT;
        we_n_nxt  = 1'b0;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) begin
          we_n_nxt  = 1'b1;
          state_nxt = WR_HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        // Data and address outlive the WE rising edge by one cycle.
        dq_oe_nxt   = 1'b0;
        ce_n_nxt    = 1'b1;
        b_valid_nxt = 1'b1;
        state_nxt   = WR_RESP;
      end
      WR_RESP: begin
        if (axi.b_ready) begin
          b_valid_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= 18'd0;
      w_data_q   <= 16'd0;
      r_valid    <= 1'b0;
      r_data     <= 16'd0;
      b_valid    <= 1'b0;
      sram_addr  <= 18'd0;
      sram_dq_o  <= 16'd0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      aw_held    <= aw_held_nxt;
      w_held     <= w_held_nxt;
      aw_addr_q  <= aw_addr_nxt;
      w_data_q   <= w_data_nxt;
      r_valid    <= r_valid_nxt;
      r_data     <= r_data_nxt;
      b_valid    <= b_valid_nxt;
      sram_addr  <= addr_nxt;
      sram_dq_o  <= dq_o_nxt;
      sram_dq_oe <= dq_oe_nxt;
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
    end
  end

endmodule
